cpu_control_unit: RTL

Fetch/decode/execute sequencer for the accumulator-style CPU core. It drives the code memory address and latches the addressed instruction, then decodes the opcode. Per instruction it sequences the synchronous data memory and the combinational ALU. It holds operand registers A, B and result register C, and runs one program from address 0 per `start` pulse until HALT.

---
 rtl/cpu_control_unit.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/cpu_control_unit.sv
// Fetch/decode/execute sequencer for the accumulator CPU: drives code/data memory and the ALU.
// Latency: NOP 2, ALU/STORE 3, LOAD 4, HALT 2 cycles (each including FETCH).
// Backpressure: none; memories respond in fixed time, start is ignored while busy.
module cpu_control_unit #(
    parameter int Instruction_WIDTH      = 16,
    parameter int Instruction_ADDR_WIDTH = 4,
    parameter int opcode_SIZE            = 4,
    parameter int DATA_WIDTH             = 8,
    parameter int DATA_ADDR_WIDTH        = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    output logic [Instruction_ADDR_WIDTH-1:0] addr,
    input  logic [Instruction_WIDTH-1:0]      instruction_read,
    output logic [DATA_ADDR_WIDTH-1:0]        dm_addr,
    output logic                              dm_rd_en,
    input  logic [DATA_WIDTH-1:0]             dm_rd_data,
    output logic                              dm_wr_en,
    output logic [DATA_WIDTH-1:0]             dm_wr_data,
    output logic [1:0]                        alu_op,
    output logic [DATA_WIDTH-1:0]             alu_a,
    output logic [DATA_WIDTH-1:0]             alu_b,
    input  logic [DATA_WIDTH-1:0]             alu_result,
    output logic [DATA_WIDTH-1:0]             result,
    output logic                              busy,
    output logic                              done,
    output logic                              error
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEM_RD, S_MEM_WB, S_EXEC, S_STORE, S_HALT
    } state_t;

    localparam logic [opcode_SIZE-1:0] OP_NOP    = opcode_SIZE'(0);
    localparam logic [opcode_SIZE-1:0] OP_LOAD_A = opcode_SIZE'(1);
    localparam logic [opcode_SIZE-1:0] OP_LOAD_B = opcode_SIZE'(2);
    localparam logic [opcode_SIZE-1:0] OP_STORE  = opcode_SIZE'(3);
    localparam logic [opcode_SIZE-1:0] OP_ADD    = opcode_SIZE'(4);
    localparam logic [opcode_SIZE-1:0] OP_SUB    = opcode_SIZE'(5);
    localparam logic [opcode_SIZE-1:0] OP_MUL    = opcode_SIZE'(6);
    localparam logic [opcode_SIZE-1:0] OP_DIV    = opcode_SIZE'(7);
    localparam logic [opcode_SIZE-1:0] OP_HALT   = opcode_SIZE'(8);

    state_t                              state_q, state_d;
    logic [Instruction_ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [Instruction_WIDTH-1:0]        ir_q, ir_d;
    logic [DATA_WIDTH-1:0]               a_q, a_d;
    logic [DATA_WIDTH-1:0]               b_q, b_d;
    logic [DATA_WIDTH-1:0]               c_q, c_d;
    logic                                err_q, err_d;

    logic [opcode_SIZE-1:0]              opcode;
    logic [DATA_ADDR_WIDTH-1:0]          operand;
    logic                                unused_ir;

    // All decode works from the latched instruction, never from the live code memory bus.
    assign opcode  = ir_q[Instruction_WIDTH-1 -: opcode_SIZE];
    assign operand = ir_q[DATA_ADDR_WIDTH-1:0];
    // Bits between the opcode and operand fields carry no meaning.
    assign unused_ir = ^ir_q;

    assign addr       = pc_q;
    assign dm_wr_data = c_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign result     = c_q;
    assign busy       = (state_q != S_IDLE) && (state_q != S_HALT);
    assign done       = (state_q == S_HALT);
    assign error      = err_q;

    // State and datapath registers; reset returns everything to zero so all outputs read 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            err_q   <= err_d;
        end
    end

    // Next-state sequencing and per-state memory/ALU strobes.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        err_d    = err_q;
        dm_rd_en = 1'b0;
        dm_wr_en = 1'b0;
        dm_addr  = '0;
        alu_op   = 2'd0;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    err_d   = 1'b0;
                end
            end
            S_FETCH: begin
                ir_d    = instruction_read;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_NOP: begin
                        pc_d    = pc_q + Instruction_ADDR_WIDTH'(1);
                        state_d = S_FETCH;
                    end
                    OP_LOAD_A, OP_LOAD_B:            state_d = S_MEM_RD;
                    OP_STORE:                        state_d = S_STORE;
                    OP_ADD, OP_SUB, OP_MUL, OP_DIV:  state_d = S_EXEC;
                    OP_HALT:                         state_d = S_HALT;
                    default: begin
                        // Illegal opcodes stop the program like HALT but flag it.
                        state_d = S_HALT;
                        err_d   = 1'b1;
                    end
                endcase
            end
            S_MEM_RD: begin
                dm_rd_en = 1'b1;
                dm_addr  = operand;
                state_d  = S_MEM_WB;
            end
            S_MEM_WB: begin
                if (opcode == OP_LOAD_A) begin
                    a_d = dm_rd_data;
                end else begin
                    b_d = dm_rd_data;
                end
                pc_d    = pc_q + Instruction_ADDR_WIDTH'(1);
                state_d = S_FETCH;
            end
            S_EXEC: begin
                // ALU opcodes 4..7 map onto alu_op 0..3 through their low two bits.
                alu_op = opcode[1:0];
                if ((opcode == OP_DIV) && (b_q == '0)) begin
                    c_d   = '1;
                    err_d = 1'b1;
                end else begin
                    c_d = alu_result;
                end
                pc_d    = pc_q + Instruction_ADDR_WIDTH'(1);
                state_d = S_FETCH;
            end
            S_STORE: begin
                dm_wr_en = 1'b1;
                dm_addr  = operand;
                pc_d     = pc_q + Instruction_ADDR_WIDTH'(1);
                state_d  = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
